// File: rtl/bcd_serial_alu.sv
// Digit-serial BCD adder/subtractor: one shared BCD digit stage,
// LSD first, with a re-complement pass for negative differences.
module bcd_serial_alu #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carry_out,
    output logic                  negative,
    output logic                  invalid
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RECOMP,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic [4*DIGITS-1:0] result_q;
    logic                mode_q;
    logic [IW-1:0]       idx_q;
    logic                c_q;
    logic                busy_q;
    logic                done_q;
    logic                carry_q;
    logic                neg_q;
    logic                inv_q;

    logic [3:0] op_x;
    logic [3:0] op_y;
    logic [3:0] op_yc;
    logic       op_comp;
    logic [4:0] z;
    logic [3:0] dig_sum;
    logic       dig_c;
    logic       last;
    logic       in_bad;

    function automatic logic has_bad(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign in_bad = has_bad(a) || has_bad(b);
    assign last   = (idx_q == IW'(DIGITS - 1));

    // RECOMP reuses the stage as 0 + (9 - r_i) + c.
    always_comb begin
        op_x    = a_q[4*idx_q +: 4];
        op_y    = b_q[4*idx_q +: 4];
        op_comp = mode_q;
        if (state_q == RECOMP) begin
            op_x    = 4'd0;
            op_y    = result_q[4*idx_q +: 4];
            op_comp = 1'b1;
        end
    end

    assign op_yc   = op_comp ? (4'd9 - op_y) : op_y;
    assign z       = {1'b0, op_x} + {1'b0, op_yc} + {4'd0, c_q};
    assign dig_c   = (z > 5'd9);
    assign dig_sum = dig_c ? (z[3:0] + 4'd6) : z[3:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = in_bad ? DONE : ADD;
            end
            ADD: begin
                if (last) state_d = (mode_q && !dig_c) ? RECOMP : DONE;
            end
            RECOMP: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            busy_q <= (state_d == ADD) || (state_d == RECOMP);
            done_q <= (state_d == DONE);
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        mode_q   <= mode;
                        result_q <= '0;
                        carry_q  <= 1'b0;
                        neg_q    <= 1'b0;
                        inv_q    <= in_bad;
                        idx_q    <= '0;
                        c_q      <= mode;
                    end
                end
                ADD: begin
                    result_q[4*idx_q +: 4] <= dig_sum;
                    c_q <= dig_c;
                    if (last) begin
                        idx_q <= '0;
                        if (!mode_q) begin
                            carry_q <= dig_c;
                        end else if (!dig_c) begin
                            neg_q <= 1'b1;
                            c_q   <= 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                RECOMP: begin
                    result_q[4*idx_q +: 4] <= dig_sum;
                    c_q <= dig_c;
                    if (last) begin
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign negative  = neg_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Directed scoreboard bench for bcd_serial_alu (DIGITS=4).
module tb_bcd_serial_alu;

    localparam int D = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic          carry_out;
    logic          negative;
    logic          invalid;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        neg;
        logic        inv;
        int          lat;
        int          bcyc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    bcd_serial_alu #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .negative  (negative),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push expectation, issue the op, then pop and compare at done.
    task automatic run_op(input string tag, input logic [15:0] ia,
                          input logic [15:0] ib, input logic im,
                          input logic [15:0] xr, input logic xc,
                          input logic xn, input logic xi,
                          input int xlat, input int xbusy,
                          input bit abuse);
        exp_t e;
        exp_t got;
        int   k;
        int   bc;
        int   ov;
        e.res = xr; e.co = xc; e.neg = xn; e.inv = xi;
        e.lat = xlat; e.bcyc = xbusy;
        @(posedge clk); #1;
        a = ia; b = ib; mode = im; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
        k = 1; bc = 0; ov = 0;
        while (done !== 1'b1 && k < 60) begin
            if (busy === 1'b1) bc++;
            if (abuse && k == 2) begin
                start = 1'b1; a = 16'h0001; b = 16'h0001; mode = 1'b0;
            end
            if (abuse && k == 3) start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        if (busy === 1'b1 && done === 1'b1) ov = 1;
        got = sb.pop_front();
        if (done !== 1'b1) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, " result"}, 32'(result), 32'(got.res));
        check({tag, " carry"}, 32'(carry_out), 32'(got.co));
        check({tag, " negative"}, 32'(negative), 32'(got.neg));
        check({tag, " invalid"}, 32'(invalid), 32'(got.inv));
        check({tag, " latency"}, 32'(k), 32'(got.lat));
        check({tag, " busy_cycles"}, 32'(bc), 32'(got.bcyc));
        check({tag, " busy_done_overlap"}, 32'(ov), 32'd0);
        if (abuse) begin
            start = 1'b1; a = 16'h0002; b = 16'h0002; mode = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, " done_pulse_len"}, 32'(done), 32'd0);
            @(posedge clk); #1;
            check({tag, " ignored_busy"}, 32'(busy), 32'd0);
            check({tag, " held_result"}, 32'(result), 32'(got.res));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        #12;
        check("rst result", 32'(result), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst flags", 32'({carry_out, negative, invalid}), 32'd0);
        rst_n = 1'b1;

        run_op("add", 16'h1234, 16'h5678, 1'b0, 16'h6912,
               1'b0, 1'b0, 1'b0, D + 1, D, 1'b0);
        run_op("add_ovf", 16'h9999, 16'h0001, 1'b0, 16'h0000,
               1'b1, 1'b0, 1'b0, D + 1, D, 1'b0);
        run_op("sub", 16'h5000, 16'h1234, 1'b1, 16'h3766,
               1'b0, 1'b0, 1'b0, D + 1, D, 1'b0);
        run_op("sub_eq", 16'h0042, 16'h0042, 1'b1, 16'h0000,
               1'b0, 1'b0, 1'b0, D + 1, D, 1'b0);
        run_op("sub_neg", 16'h1234, 16'h5000, 1'b1, 16'h3766,
               1'b0, 1'b1, 1'b0, 2 * D + 1, 2 * D, 1'b0);
        run_op("sub_neg1", 16'h0000, 16'h0001, 1'b1, 16'h0001,
               1'b0, 1'b1, 1'b0, 2 * D + 1, 2 * D, 1'b0);
        run_op("invalid", 16'h12A4, 16'h0003, 1'b0, 16'h0000,
               1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        run_op("after_inv", 16'h0005, 16'h0007, 1'b0, 16'h0012,
               1'b0, 1'b0, 1'b0, D + 1, D, 1'b0);
        run_op("abuse", 16'h0808, 16'h0909, 1'b0, 16'h1717,
               1'b0, 1'b0, 1'b0, D + 1, D, 1'b1);

        // Abort a negative subtract while it is re-complementing.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h5000; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (D) @(posedge clk);
        #1;
        check("recomp busy", 32'(busy), 32'd1);
        check("recomp neg", 32'(negative), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort result", 32'(result), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort flags", 32'({carry_out, negative, invalid}), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 2 * D; i++) begin
                @(posedge clk); #1;
                if (done === 1'b1) seen = 1;
                if (i == 2) rst_n = 1'b1;
            end
            check("abort no_done", 32'(seen), 32'd0);
        end

        run_op("post_rst", 16'h0999, 16'h0001, 1'b0, 16'h1000,
               1'b0, 1'b0, 1'b0, D + 1, D, 1'b0);
        run_op("post_rst_sub", 16'h0100, 16'h0999, 1'b1, 16'h0899,
               1'b0, 1'b1, 1'b0, 2 * D + 1, 2 * D, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_serial_alu.md
# bcd_serial_alu

Digit-serial multi-digit BCD adder/subtractor controller. It accepts two DIGITS-wide packed-BCD operands and an add/subtract mode. It sequences one shared single-digit BCD add stage (nine's-complement generator feeding a 4-bit BCD adder with decimal correction) over the digits, least-significant digit first. For negative differences it runs a second pass that re-complements the result into sign-magnitude form. It sits between the operand registers and the display/result path of the BCD calculator datapath.

## Interface

Reset is asynchronous and active-low; one clock.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = A+B, 1 = A−B; captured with start.
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  in  4*DIGITS  operand B, same packing.
- busy  out  1  high in ADD and RECOMP.
- done  out  1  one-cycle pulse when result and flags are valid.
- result  out  4*DIGITS  BCD magnitude.
- carry_out  out  1  add overflow (decimal carry out of the top digit); 0 for subtract.
- negative  out  1  subtract result is negative (A<B); 0 for add.
- invalid  out  1  an operand digit was >9 at capture.

## Operation

- States: IDLE, ADD, RECOMP, DONE.
- **IDLE, start=1:**
  - Capture a, b and mode into operand registers.
  - Clear result, carry_out, negative and invalid.
  - Set the digit index to 0 and the carry register to mode (subtract uses +1 for ten's complement).
  - If any captured digit is >9: set invalid and go to DONE, leaving result at 0.
  - Otherwise go to ADD.
- **ADD, one digit per cycle, digit i = index:**
  - b' = b_i when mode=0, else 9−b_i.
  - z = a_i + b' + c (5-bit).
  - If z>9: digit = z+6 mod 16 and c=1; else digit = z and c=0.
  - Write the digit into result[4i+3:4i], then increment the index.
  - After digit DIGITS−1:
    - mode=0: carry_out = final c, go to DONE.
    - mode=1 and final c=1: A≥B, result already correct, go to DONE.
    - mode=1 and final c=0: set negative, reset the index to 0 with c=1, go to RECOMP.
- **RECOMP, one digit per cycle:** result_i := BCD(9 − result_i + c) with the same correction and carry rule. Go to DONE after digit DIGITS−1.
- **DONE:**
  - done=1 for exactly one cycle, then return to IDLE.
  - start is ignored in DONE.
- start is ignored in ADD, RECOMP and DONE. Operand inputs may change freely after capture.
- result and all flags hold their values from DONE until the next accepted start.
- Every stored digit is a legal BCD value (0–9).
- A−B with A=B gives result 0, negative=0.

## Timing

- Reset values: state IDLE; busy, done, carry_out, negative and invalid all 0; result all 0; index 0; carry register 0.
- Reset asserted mid-operation aborts immediately to these values. No done is produced for the aborted operation.
- Let start be sampled high at rising edge T0.
  - busy rises after T0.
  - Add, or non-negative subtract: done is high in cycle DIGITS+1 after T0. Latency is DIGITS+1 cycles; busy is high for DIGITS cycles.
  - Negative subtract: done is high in cycle 2·DIGITS+1; busy is high for 2·DIGITS cycles.
  - Invalid operand: done is high in cycle 1 after T0 and busy never rises.
- busy and done are never high in the same cycle.
- A new start is earliest accepted the cycle after done, giving a back-to-back throughput of one operation per DIGITS+2 cycles (non-negative case).
- All outputs are registered; no combinational input-to-output path.

## Test plan

Operands below are shown as hex-packed BCD with DIGITS=4.

1. Add, a=1234, b=5678, mode=0 → result=6912, carry_out=0, negative=0. done exactly 5 cycles after start and busy high for 4 cycles.
2. Add overflow, a=9999, b=0001 → result=0000, carry_out=1. Same latency as scenario 1.
3. Subtract, a=5000, b=1234, mode=1 → result=3766, negative=0, done at cycle 5.
   - Also a=0042, b=0042 → result=0000, negative=0.
4. Negative subtract, a=1234, b=5000 → result=3766, negative=1, done at cycle 9 and busy high for 8 cycles.
   - Also a=0000, b=0001 → result=0001, negative=1.
5. Invalid operand, a=12A4 (digit 1 = 0xA) → invalid=1, result=0000, done at cycle 1, busy never high.
   - The next valid start clears invalid.
6. Control abuse:
   - Pulse start again during ADD and during DONE → ignored, first result unchanged.
   - Drop rst_n during RECOMP → all outputs 0 asynchronously, no done.
   - A fresh start after reset completes correctly.
